// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state type for the ahb_arbiter slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Beats remaining after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index above rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [1:0]             rr_ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic                   valid
);

  localparam int unsigned NM = NUM_MASTERS;
  localparam int unsigned IW = (NM > 2) ? 2 : 1;

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // k = NM lands back on rr_ptr, so the current owner is considered last.
    for (int unsigned k = 1; k <= NM; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NM);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst, lock and SPLIT awareness.
// Define AHB_ARB_SPLIT_EN to enable split masking driven by hsplit.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic                   hmastlock
);

  localparam int unsigned            NM         = NUM_MASTERS;
  localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t            state;
  logic [3:0]            beats_left;
  logic [1:0]            rr_ptr;
  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] winner;
  logic                  pick_valid;
  logic [NUM_MASTERS-1:0] next_grant;
  logic [1:0]            next_idx;
  logic                  owner_locks;
  logic                  burst_start;

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_set;

  always_comb begin
    split_set = '0;
    if (hready && hresp == HRESP_SPLIT)
      split_set[hmaster] = 1'b1;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) split_mask <= '0;
    else        split_mask <= (split_mask | split_set) & ~hsplit;
  end
`else
  logic unused_hsplit;
  assign unused_hsplit = ^hsplit;
  assign split_mask    = '0;
`endif

  assign eligible = hbusreq & ~split_mask;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .valid    (pick_valid)
  );

  always_comb begin
    next_idx = 2'(DEFAULT_MASTER);
    for (int unsigned i = 0; i < NM; i++)
      if (winner[i]) next_idx = 2'(i);
  end

  assign next_grant = pick_valid ? winner : PARK_GRANT;

  // rr_ptr always equals index(hgrant), so it also names the granted master.
  assign owner_locks = hlock[rr_ptr] & hbusreq[rr_ptr];
  assign burst_start = (htrans == HTRANS_NONSEQ) && (hburst >= HBURST_WRAP4);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= ARB;
      beats_left <= '0;
      rr_ptr     <= 2'(DEFAULT_MASTER);
      hgrant     <= PARK_GRANT;
      hmaster    <= 2'(DEFAULT_MASTER);
      hmastlock  <= 1'b0;
    end else if (!hready) begin
      if (hresp != HRESP_OKAY) begin
        state      <= ARB;
        beats_left <= '0;
      end
    end else begin
      hmaster   <= rr_ptr;
      hmastlock <= hlock[rr_ptr];
      case (state)
        ARB: begin
          if (owner_locks) begin
            state <= LOCKED;
          end else if (burst_start) begin
            state      <= BURST;
            beats_left <= burst_beats_left(hburst);
          end else begin
            hgrant <= next_grant;
            rr_ptr <= next_idx;
          end
        end
        BURST: begin
          if (htrans == HTRANS_SEQ) begin
            beats_left <= beats_left - 4'd1;
            // The beat that leaves one remaining is itself an arbitration
            // point, so the new grant overlaps the final beat.
            if (beats_left == 4'd2) begin
              if (owner_locks) begin
                state <= LOCKED;
              end else begin
                state  <= ARB;
                hgrant <= next_grant;
                rr_ptr <= next_idx;
              end
            end
          end
        end
        LOCKED: begin
          if (!hlock[rr_ptr]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
